// File: rtl/noc_sync_pkg.sv
// Shared types and constants for the synchronous NoC leaf blocks.
// Flits carry a tail flag in the top bit; the remaining bits are payload.
package noc_sync_pkg;

    localparam int FLIT_W   = 9;
    localparam int TAIL_BIT = FLIT_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              tail;
        logic [FLIT_W-2:0] payload;
    } flit_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is presented
// directly and reads as zero while empty.
module noc_sync_fifo
    import noc_sync_pkg::*;
#(
    parameter int WIDTH = FLIT_W + 1,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             _RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/merge13_leaf_sync.sv
// Merges two decoder-leaf flit streams into one, keeping packets whole via a
// lock-on-header arbiter with round-robin tie breaking, buffered by a FIFO.
module merge13_leaf_sync
    import noc_sync_pkg::*;
#(
    parameter int W     = FLIT_W,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_src,
    input  logic         out_ready
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       rr;
    logic       rr_nxt;
    logic       grant0;
    logic       grant1;
    logic       acc0;
    logic       acc1;
    logic       tail_in;
    logic       fifo_full;
    logic       fifo_empty;
    logic [W:0] push_data;
    logic [W:0] head_data;

    // Grant follows the lock while a packet is open; otherwise a lone requester
    // wins and a tie is broken by rr.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    grant0 = !rr;
                    grant1 = rr;
                end else begin
                    grant0 = in0_valid;
                    grant1 = in1_valid;
                end
            end
            LOCK0:   grant0 = 1'b1;
            LOCK1:   grant1 = 1'b1;
            default: ;
        endcase
    end

    assign in0_ready = grant0 && !fifo_full && _RESET;
    assign in1_ready = grant1 && !fifo_full && _RESET;
    assign acc0      = in0_valid && in0_ready;
    assign acc1      = in1_valid && in1_ready;
    assign tail_in   = acc1 ? in1_data[W-1] : in0_data[W-1];
    assign push_data = acc1 ? {1'b1, in1_data} : {1'b0, in0_data};

    // A tail closes the packet and hands priority to the other port.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        if (acc0 || acc1) begin
            if (tail_in) begin
                state_nxt = IDLE;
                rr_nxt    = acc0;
            end else begin
                state_nxt = acc1 ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state <= IDLE;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
        end
    end

    noc_sync_fifo #(
        .WIDTH (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .push      (acc0 || acc1),
        .push_data (push_data),
        .pop       (out_ready),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid = !fifo_empty;
    assign out_src   = head_data[W];
    assign out_data  = head_data[W-1:0];

endmodule

// File: tb/tb_merge13_leaf_sync.sv
// Bench for merge13_leaf_sync: directed packet scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the merge behaviour.
module tb_merge13_leaf_sync;

    localparam int W     = 9;
    localparam int DEPTH = 2;

    logic         CLK = 1'b0;
    logic         _RESET = 1'b1;
    logic [W-1:0] in0_data = '0;
    logic         in0_valid = 1'b0;
    logic         in0_ready;
    logic [W-1:0] in1_data = '0;
    logic         in1_valid = 1'b0;
    logic         in1_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_src;
    logic         out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: open-packet owner (-1 none), tie-break port, expected FIFO contents.
    int         lock_m = -1;
    int         rr_m   = 0;
    logic [W:0] exp_q[$];

    logic [W:0]   obs_log[$];
    longint       obs_time[$];
    logic [W:0]   ref_log[$];
    logic [W-1:0] src0_q[$];
    logic [W-1:0] src1_q[$];
    bit           in1_early = 1'b0;

    merge13_leaf_sync #(.W(W), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int granted_m();
        if (lock_m >= 0) return lock_m;
        if (in0_valid && in1_valid) return rr_m;
        if (in0_valid) return 0;
        if (in1_valid) return 1;
        return -1;
    endfunction

    // Reference model: advances on each rising edge from the bench's own view of the rules.
    always @(posedge CLK or negedge _RESET) begin
        int         g;
        bit         room;
        bit         a0;
        bit         a1;
        logic [W-1:0] f;
        if (!_RESET) begin
            exp_q.delete();
            lock_m = -1;
            rr_m   = 0;
        end else begin
            g    = granted_m();
            room = (exp_q.size() < DEPTH);
            a0   = (g == 0) && in0_valid && room;
            a1   = (g == 1) && in1_valid && room;
            if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (a0 || a1) begin
                f = a1 ? in1_data : in0_data;
                exp_q.push_back({a1, f});
                if (f[W-1]) begin
                    lock_m = -1;
                    rr_m   = a1 ? 0 : 1;
                end else begin
                    lock_m = a1 ? 1 : 0;
                end
            end
        end
    end

    // Compare process: mid-cycle, all inputs and outputs are settled.
    always @(negedge CLK) begin
        int g;
        bit room;
        if (!_RESET) begin
            check_output("rst_in0_ready", in0_ready, 0);
            check_output("rst_in1_ready", in1_ready, 0);
            check_output("rst_out_valid", out_valid, 0);
            check_output("rst_out_data", out_data, 0);
            check_output("rst_out_src", out_src, 0);
        end else begin
            g    = granted_m();
            room = (exp_q.size() < DEPTH);
            check_output("in0_ready", in0_ready, int'((g == 0) && room));
            check_output("in1_ready", in1_ready, int'((g == 1) && room));
            check_output("out_valid", out_valid, int'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check_output("out_data", out_data, exp_q[0][W-1:0]);
                check_output("out_src", out_src, exp_q[0][W]);
            end
            if (out_valid && out_ready) begin
                obs_log.push_back({out_src, out_data});
                obs_time.push_back($time);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_stimulus(input bit gaps, output bit a0, output bit a1, output bit r1);
        in0_valid = (src0_q.size() > 0) && (!gaps || $urandom_range(3) != 0);
        in0_data  = (src0_q.size() > 0) ? src0_q[0] : '0;
        in1_valid = (src1_q.size() > 0) && (!gaps || $urandom_range(3) != 0);
        in1_data  = (src1_q.size() > 0) ? src1_q[0] : '0;
        @(negedge CLK);
        a0 = in0_valid && in0_ready;
        a1 = in1_valid && in1_ready;
        r1 = in1_ready;
        @(posedge CLK);
        #1;
        if (a0) void'(src0_q.pop_front());
        if (a1) void'(src1_q.pop_front());
    endtask

    task automatic run_streams(input int max_cycles, input bit must_finish, input bit gaps);
        bit a0, a1, r1, pend0;
        for (int c = 0; c < max_cycles && (src0_q.size() > 0 || src1_q.size() > 0); c++) begin
            pend0 = (src0_q.size() > 0);
            apply_stimulus(gaps, a0, a1, r1);
            if (pend0 && r1) in1_early = 1'b1;
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        if (must_finish) check_output("stream_done", src0_q.size() + src1_q.size(), 0);
    endtask

    task automatic check_log(input string name);
        int n;
        check_output({name, "_len"}, obs_log.size(), ref_log.size());
        n = (obs_log.size() < ref_log.size()) ? obs_log.size() : ref_log.size();
        for (int i = 0; i < n; i++) check_output(name, obs_log[i], ref_log[i]);
    endtask

    task automatic do_reset(input int cycles);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        _RESET    = 1'b0;
        idle(cycles);
        _RESET    = 1'b1;
    endtask

    initial begin
        bit a0, a1, r1;

        // Reset with a flit already offered: nothing may be accepted yet.
        #2;
        _RESET    = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 9'h1AB;
        out_ready = 1'b1;
        #1;
        check_output("rst_hold_in0_ready", in0_ready, 0);
        check_output("rst_hold_out_valid", out_valid, 0);
        idle(2);
        _RESET = 1'b1;

        // Single tail flit on in0 appears right after its accepting edge.
        #1;
        check_output("first_in0_ready", in0_ready, 1);
        src0_q = '{9'h1AB};
        run_streams(5, 1'b1, 1'b0);
        check_output("single_out_valid", out_valid, 1);
        check_output("single_out_data", out_data, 9'h1AB);
        check_output("single_out_src", out_src, 0);

        // rr now points at in1, so a tie goes to in1.
        obs_log.delete();
        in0_valid = 1'b1;
        in0_data  = 9'h111;
        in1_valid = 1'b1;
        in1_data  = 9'h122;
        #1;
        check_output("rr_tie_in1_ready", in1_ready, 1);
        check_output("rr_tie_in0_ready", in0_ready, 0);
        src0_q = '{9'h111};
        src1_q = '{9'h122};
        run_streams(10, 1'b1, 1'b0);
        idle(3);
        ref_log = '{{1'b0, 9'h1AB}, {1'b1, 9'h122}, {1'b0, 9'h111}};
        check_log("rr_order");

        // Reset while in1 holds an open packet: lock and buffered header vanish.
        src1_q = '{9'h055};
        run_streams(5, 1'b1, 1'b0);
        _RESET = 1'b0;
        #1;
        check_output("midpkt_rst_out_valid", out_valid, 0);
        idle(1);
        _RESET    = 1'b1;
        in0_valid = 1'b1;
        in0_data  = 9'h1C3;
        #1;
        check_output("post_rst_in0_ready", in0_ready, 1);
        src0_q = '{9'h1C3};
        run_streams(5, 1'b1, 1'b0);
        check_output("post_rst_out_data", out_data, 9'h1C3);
        check_output("post_rst_out_src", out_src, 0);
        idle(3);

        // Three-flit in0 packet beats a waiting in1 flit and is never interleaved.
        do_reset(2);
        obs_log.delete();
        in1_early = 1'b0;
        src0_q = '{9'h001, 9'h002, 9'h103};
        src1_q = '{9'h1FF};
        run_streams(20, 1'b1, 1'b0);
        idle(3);
        ref_log = '{{1'b0, 9'h001}, {1'b0, 9'h002}, {1'b0, 9'h103}, {1'b1, 9'h1FF}};
        check_log("pkt_order");
        check_output("in1_ready_during_pkt", in1_early, 0);

        // Stalled output: only DEPTH flits fit, the head stays put.
        obs_log.delete();
        out_ready = 1'b0;
        src0_q = '{9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3};
        run_streams(6, 1'b0, 1'b0);
        check_output("stall_accepted", 4 - src0_q.size(), 2);
        in0_valid = 1'b1;
        in0_data  = src0_q[0];
        #1;
        check_output("stall_in0_ready", in0_ready, 0);
        check_output("stall_out_data", out_data, 9'h1A0);
        out_ready = 1'b1;
        run_streams(20, 1'b1, 1'b0);
        idle(3);
        ref_log = '{{1'b0, 9'h1A0}, {1'b0, 9'h1A1}, {1'b0, 9'h1A2}, {1'b0, 9'h1A3}};
        check_log("stall_order");

        // Both ports streaming single-flit packets alternate at full rate.
        obs_log.delete();
        obs_time.delete();
        for (int i = 0; i < 6; i++) begin
            src0_q.push_back(9'h100 | 9'(i));
            src1_q.push_back(9'h180 | 9'(i));
        end
        run_streams(30, 1'b1, 1'b0);
        idle(3);
        check_output("alt_count", obs_log.size(), 12);
        for (int i = 1; i < obs_log.size(); i++) begin
            check_output("alt_src_toggle", int'(obs_log[i][W] != obs_log[i-1][W]), 1);
            check_output("alt_rate", int'(obs_time[i] - obs_time[i-1]), 10);
        end

        // Randomized traffic with back-pressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (src0_q.size() == 0 && $urandom_range(2) == 0) begin
                int len = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) begin
                    logic [W-1:0] f;
                    f = W'($urandom);
                    f[W-1] = (k == len - 1);
                    src0_q.push_back(f);
                end
            end
            if (src1_q.size() == 0 && $urandom_range(2) == 0) begin
                int len = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) begin
                    logic [W-1:0] f;
                    f = W'($urandom);
                    f[W-1] = (k == len - 1);
                    src1_q.push_back(f);
                end
            end
            if ($urandom_range(499) == 0) begin
                src0_q.delete();
                src1_q.delete();
                do_reset(1);
            end
            out_ready = ($urandom_range(3) != 0);
            apply_stimulus(1'b1, a0, a1, r1);
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        idle(5);
        check_output("final_drained", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/merge13_leaf_sync.md
MERGE13_LEAF_SYNC -- requirements
Module: merge13_leaf_sync

Interface
REQ-001 W, 9, flit width; bit W-1 is the tail flag, bits W-2:0 are payload.
REQ-002 DEPTH, 2, output FIFO entries; power of two, at least 2.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 _RESET  input  1  asynchronous, active-low reset.
REQ-005 in0_data  input  W  flit from decoder leaf Out0 side.
REQ-006 in0_valid  input  1  in0_data holds a flit.
REQ-007 in0_ready  output  1  block accepts in0 flit this cycle.
REQ-008 in1_data  input  W  flit from decoder leaf Out1 side.
REQ-009 in1_valid  input  1  in1_data holds a flit.
REQ-010 in1_ready  output  1  block accepts in1 flit this cycle.
REQ-011 out_data  output  W  merged flit.
REQ-012 out_valid  output  1  out_data/out_src hold a flit.
REQ-013 out_src  output  1  source port of current out flit (0 = in0, 1 = in1).
REQ-014 out_ready  input  1  consumer accepts the out flit this cycle.

Function
REQ-015 A transfer on any port SHALL occur at a rising CLK edge where valid and ready are both high.
REQ-016 While out_valid is high and out_ready low, out_data and out_src SHALL hold stable.
REQ-017 Arbiter FSM SHALL have states IDLE, LOCK0, LOCK1.
REQ-018 IDLE: a sole valid input is granted; with both valid, the port selected by the round-robin pointer rr is granted.
REQ-019 IDLE, granted flit transferred with tail=0 -> LOCKn (n = granted port); with tail=1 -> stay IDLE.
REQ-020 LOCKn: only port n is granted; on transfer of a tail=1 flit -> IDLE.
REQ-021 On every tail-flit transfer from port n, rr SHALL become the other port; rr is unchanged otherwise.
REQ-022 inN_ready SHALL be high iff port N is granted and FIFO count is below DEPTH; the ungranted port's ready SHALL be 0.
REQ-023 Grant and ready SHALL be combinational from FSM state, rr, valids and FIFO count; the data path SHALL be fully registered (no input-to-output combinational path).
REQ-024 Accepted flits SHALL be pushed into the FIFO as {src, data}; out_valid = FIFO not empty; out presents the head entry.
REQ-025 Latency: a flit accepted at edge N SHALL appear on out with out_valid high immediately after edge N when the FIFO was empty.
REQ-026 Throughput: one flit per cycle SHALL be sustained while out_ready is held high.
REQ-027 Push and pop in the same cycle SHALL leave the count unchanged.
REQ-028 When full, no push SHALL occur even if a pop occurs that cycle.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-030 Flits of one packet SHALL never interleave with flits of the other port at the output.

Reset
REQ-031 While _RESET is low: FSM = IDLE, rr = 0, FIFO empty, out_valid = 0, in0_ready = in1_ready = 0, out_data = 0, out_src = 0.
REQ-032 Reset asserted mid-packet SHALL discard the lock and all FIFO contents with no out transfer; the partial packet is lost.
REQ-033 The first input acceptance SHALL occur no earlier than the first rising edge after _RESET deasserts.

Structure
REQ-034 Package noc_sync_pkg SHALL hold the default flit width, the tail-bit index, arb_state_t (IDLE/LOCK0/LOCK1), and flit_t {tail, payload}.
REQ-035 The FIFO SHALL be a separate sub-module, noc_sync_fifo, parameterized by width and DEPTH; the arbiter FSM stays in the top module.

Verification
REQ-036 Reset then in0 single flit 0x1AB (tail=1), out_ready=1 -> out_data=0x1AB, out_src=0 one cycle later; rr=1.
REQ-037 Both valid from IDLE, rr=0, in0 three flits 0x001, 0x002, 0x103, in1 0x1FF -> out order 0x001, 0x002, 0x103, 0x1FF; in1_ready=0 throughout the in0 packet.
REQ-038 out_ready=0, in0 streams 4 single-flit packets -> exactly 2 accepted, then in0_ready=0; out holds the first flit stable; release -> all 4 delivered in order.
REQ-039 Both ports stream single-flit packets continuously with out_ready=1 -> strict alternation 0,1,0,1 on out_src at one flit/cycle.
REQ-040 _RESET pulsed low after in1 header 0x055 (tail=0) -> out_valid=0, FIFO empty, state IDLE; the next in0 tail flit is granted immediately.
